// File: rtl/timer_digit_demux.sv
// -----------------------------------------------------------------------------
// timer_digit_demux
// Demultiplexing end of the microwave timer input path. Successive key digits
// are shifted into the four MM:SS BCD digit registers; ENTER offers the
// composed time to the countdown timer over a valid/ready handshake.
//
// Ports:
//   clk            system clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   key_valid_i    key held level (one rising edge = one key event)
//   key_code_i     0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF ignored
//   load_ready_i   countdown timer accepts the offered time
//   min_tens_o,
//   min_ones_o,
//   sec_tens_o,
//   sec_ones_o     BCD digit registers
//   digit_count_o  digits entered, 0-4
//   load_valid_o   time offered to the timer
//   entry_err_o    one-cycle pulse on a rejected ENTER
//
// Configuration macro: TIMER_SEC_NORMALIZE_EN
//   When defined, ENTER with seconds tens > 5 normalizes MM:SS (seconds - 60,
//   minutes + 1) instead of rejecting, unless minutes are already 99.
// -----------------------------------------------------------------------------
module timer_digit_demux #(
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       load_ready_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic [2:0] digit_count_o,
  output logic       load_valid_o,
  output logic       entry_err_o
);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [2:0] MAX_COUNT = 3'(DIGITS);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOADED = 2'd2
  } state_e;

  state_e     state_q;
  logic       key_q;
  logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [2:0] count_q;
  logic       load_valid_q;
  logic       entry_err_q;

  logic       key_event_s;
  logic       is_digit_s;
  logic       sec_ok_s;

  // Key event qualification: rising edge of the held key level.
  always_comb begin
    key_event_s = key_valid_i & ~key_q;
    is_digit_s  = (key_code_i <= 4'd9);
    sec_ok_s    = (sec_tens_q <= 4'd5);
  end

  // Entry state machine, digit registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      key_q        <= 1'b0;
      min_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      sec_ones_q   <= 4'd0;
      count_q      <= 3'd0;
      load_valid_q <= 1'b0;
      entry_err_q  <= 1'b0;
    end else begin
      key_q       <= key_valid_i;
      entry_err_q <= 1'b0;
      case (state_q)
        ST_EMPTY, ST_ENTRY: begin
          if (key_event_s) begin
            if (is_digit_s) begin
              // A fifth digit is dropped rather than scrolling the entry.
              if (count_q < MAX_COUNT) begin
                min_tens_q <= min_ones_q;
                min_ones_q <= sec_tens_q;
                sec_tens_q <= sec_ones_q;
                sec_ones_q <= key_code_i;
                count_q    <= count_q + 3'd1;
                state_q    <= ST_ENTRY;
              end else begin
                count_q <= count_q;
              end
            end else if (key_code_i == KEY_CLEAR) begin
              min_tens_q <= 4'd0;
              min_ones_q <= 4'd0;
              sec_tens_q <= 4'd0;
              sec_ones_q <= 4'd0;
              count_q    <= 3'd0;
              state_q    <= ST_EMPTY;
            end else if ((key_code_i == KEY_ENTER) && (state_q == ST_ENTRY)) begin
              if (sec_ok_s) begin
                load_valid_q <= 1'b1;
                state_q      <= ST_LOADED;
              end
`ifdef TIMER_SEC_NORMALIZE_EN
              // Seconds 60-99 roll one minute over; 99 minutes cannot absorb it.
              else if (!((min_tens_q == 4'd9) && (min_ones_q == 4'd9))) begin
                sec_tens_q <= sec_tens_q - 4'd6;
                if (min_ones_q == 4'd9) begin
                  min_ones_q <= 4'd0;
                  min_tens_q <= min_tens_q + 4'd1;
                end else begin
                  min_ones_q <= min_ones_q + 4'd1;
                end
                load_valid_q <= 1'b1;
                state_q      <= ST_LOADED;
              end
`endif
              else begin
                entry_err_q <= 1'b1;
              end
            end else begin
              // ENTER while empty and codes 0xC-0xF have no effect.
              state_q <= state_q;
            end
          end else begin
            state_q <= state_q;
          end
        end
        ST_LOADED: begin
          // Keys are ignored here; only the handshake leaves this state.
          if (load_ready_i) begin
            min_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            sec_ones_q   <= 4'd0;
            count_q      <= 3'd0;
            load_valid_q <= 1'b0;
            state_q      <= ST_EMPTY;
          end else begin
            load_valid_q <= 1'b1;
          end
        end
        default: begin
          min_tens_q   <= 4'd0;
          min_ones_q   <= 4'd0;
          sec_tens_q   <= 4'd0;
          sec_ones_q   <= 4'd0;
          count_q      <= 3'd0;
          load_valid_q <= 1'b0;
          state_q      <= ST_EMPTY;
        end
      endcase
    end
  end

  assign min_tens_o    = min_tens_q;
  assign min_ones_o    = min_ones_q;
  assign sec_tens_o    = sec_tens_q;
  assign sec_ones_o    = sec_ones_q;
  assign digit_count_o = count_q;
  assign load_valid_o  = load_valid_q;
  assign entry_err_o   = entry_err_q;

endmodule

// File: doc/timer_digit_demux.md
# timer_digit_demux

Demultiplexing end of the microwave timer input path. It takes the single selected key stream (`key_code` with a `key_valid` strobe) and steers successive digits into the four MM:SS timer digit registers. On ENTER it offers the composed time to the countdown timer over a valid/ready handshake. It sits between the timer-input MUX and the countdown/display logic.

## Interface
- `DIGITS`, 4, number of BCD digit registers; fixed at 4 (MM:SS); other values unsupported.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  level from MUX; high while a key is held; one rising edge equals one key event.
- `key_code`  in  4  0–9 digit, 0xA CLEAR, 0xB ENTER, 0xC–0xF ignored; stable whenever `key_valid`=1.
- `load_ready`  in  1  countdown timer accepts the offered time.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digit registers.
- `digit_count`  out  3  digits entered, 0–4.
- `load_valid`  out  1  time offered to timer.
- `entry_err`  out  1  one-cycle pulse on a rejected ENTER.

## Operation
- Edge detect: `key_q` is a registered copy of `key_valid`. A key event occurs when `key_valid`=1 and `key_q`=0. `key_code` is sampled on that same edge.
- States:
  - EMPTY: `digit_count`=0.
  - ENTRY: `digit_count` is 1–4.
  - LOADED: `load_valid`=1.
- Digit event (EMPTY/ENTRY, count<4):
  - Shift left: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←code.
  - Increment count; go to ENTRY.
  - A digit 0 counts as a digit.
- Digit event at count=4: ignored; registers and count unchanged.
- CLEAR (EMPTY/ENTRY): all digits←0, count←0, go to EMPTY.
- ENTER:
  - In EMPTY: ignored.
  - In ENTRY with `sec_tens`≤5: go to LOADED.
  - In ENTRY with `sec_tens`>5: pulse `entry_err`, stay in ENTRY; see Configuration.
- LOADED:
  - All key events are ignored, CLEAR included. The offer is never withdrawn.
  - Digits are held stable.
  - When `load_valid`=1 and `load_ready`=1 on an edge: digits←0, count←0, go to EMPTY.
- Codes 0xC–0xF: ignored in every state.
- Simultaneous events: a key event on the handshake-completing edge is discarded. Only one key event is possible per edge, so there are no key/key conflicts.

## Timing
- Reset (async, immediate) values:
  - all digits 0, `digit_count`=0, state EMPTY;
  - `load_valid`=0, `entry_err`=0, `key_q`=0.
- Reset asserted mid-entry or in LOADED discards the entry immediately.
- A key held high across reset release produces a key event on the first clock after release, because `key_q`=0.
- Latency:
  - `key_valid` rises before edge k; digit registers and count update at edge k, visible in cycle k+1.
  - ENTER accepted at edge k → `load_valid`=1 from cycle k+1.
  - `entry_err` is high for exactly cycle k+1.
- Handshake: `load_valid` stays high until the first edge with `load_ready`=1. It is low in the following cycle.
- `load_ready` held high before `load_valid` rises completes the transfer one cycle after ENTER is accepted.
- A key held for N cycles yields one event. Release for at least one cycle before the next event.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `TIMER_SEC_NORMALIZE_EN`
  - Defined: ENTER with `sec_tens`>5 and minutes<99 is accepted.
    - Seconds are normalized to seconds−60 (BCD) and minutes to minutes+1 (BCD, with carry into `min_tens`). This update happens on the accepting edge; then go to LOADED.
    - Example: 01:75 → 02:15.
    - With minutes=99, pulse `entry_err` and stay in ENTRY.
  - Undefined: any ENTER with `sec_tens`>5 pulses `entry_err` and stays in ENTRY. No arithmetic logic is built.

## Test plan
- Reset, then keys 1,2,3,0, then ENTER with `load_ready`=0 → digits 1,2,3,0; count 4. `load_valid` is held for 5 cycles. `load_ready` pulse → next cycle `load_valid`=0, digits 0, count 0.
- Keys 4,5; `key_valid` held 6 cycles per key; then a fifth digit after 1,2,3,4 → one shift per key; 1,2,3,4 retained and the 5th ignored.
- Keys 9,0, CLEAR, ENTER → digits 0, count 0, no `load_valid`, no `entry_err`.
- Keys 0,1,7,5, ENTER:
  - macro off → `entry_err` for one cycle, state stays ENTRY;
  - macro on → offered time 02:15.
  - Keys 9,9,7,0 with macro on → `entry_err`.
- In LOADED, send CLEAR, key 8, and code 0xE, then complete the handshake on the same edge as another key event → digits unchanged until the handshake; all keys discarded; EMPTY afterwards.
- Assert `rst_n`=0 asynchronously mid-entry (count 2) and in LOADED → outputs are zero at once without a clock edge; after release with `key_valid` held high, a digit is captured on the first edge.
